// File: rtl/seq_alu_pkg.sv
// seq_alu_pkg: opcode constants and FSM state type shared by the sequential ALU.
package seq_alu_pkg;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_DIV = 4'h3;
  localparam logic [3:0] OP_MUL = 4'h4;
  typedef enum logic [1:0] {IDLE, CALC, FIN} state_e;
endpackage

// File: rtl/seq_alu_divider.sv
// seq_alu_divider: restoring-divide step datapath, one quotient bit per step, MSB first.
module seq_alu_divider
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             load_i,
  input  logic             step_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);
  logic [WIDTH-1:0] rem_q, quo_q;
  logic [WIDTH:0]   trial;
  // rem_o/quo_o are the post-step values so the final step can be captured directly
  assign trial = {rem_q, quo_q[WIDTH-1]} - {1'b0, divisor_i};
  assign rem_o = trial[WIDTH] ? {rem_q[WIDTH-2:0], quo_q[WIDTH-1]} : trial[WIDTH-1:0];
  assign quo_o = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
  always_ff @(posedge clk) begin
    if (load_i) begin
      rem_q <= '0;
      quo_q <= dividend_i;
    end else if (step_i) begin
      rem_q <= rem_o;
      quo_q <= quo_o;
    end
  end
endmodule

// File: rtl/seq_alu.sv
// seq_alu: multi-cycle ADD/SUB/shift-add MUL/restoring DIV with busy/done handshake.
// Define SEQ_ALU_EARLY_EXIT_EN to end MUL once the remaining multiplier bits are zero.
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic               hz100,
  input  logic               reset,
  input  logic               start,
  input  logic [3:0]         opcode,
  input  logic [WIDTH-1:0]   val_a,
  input  logic [WIDTH-1:0]   val_b,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [2*WIDTH-1:0] result
);
  localparam int CW = $clog2(WIDTH);
  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [3:0]         op_q;
  logic [WIDTH-1:0]   a_q, b_q, mplier_q, rem_nx, quo_nx;
  logic [2*WIDTH-1:0] mcand_q, acc_q, acc_nx, res_q, res_nx, wa, wb;
  logic               err_q, err_nx, accept, last, mul_done, div_zero;
  assign accept   = start && state_q != CALC;
  assign wa       = {{WIDTH{1'b0}}, a_q};
  assign wb       = {{WIDTH{1'b0}}, b_q};
  assign acc_nx   = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign div_zero = op_q == OP_DIV && b_q == '0;
`ifdef SEQ_ALU_EARLY_EXIT_EN
  assign mul_done = (mplier_q >> 1) == '0;
`else
  assign mul_done = 1'b0;
`endif
  assign last   = state_q == CALC && (cnt_q == '0 || (op_q == OP_MUL && mul_done));
  assign err_nx = !(op_q inside {OP_ADD, OP_SUB, OP_DIV, OP_MUL}) || div_zero;
  assign res_nx = err_nx ? '0 :
                  op_q == OP_ADD ? wa + wb :
                  op_q == OP_SUB ? wa - wb :
                  op_q == OP_MUL ? acc_nx : {rem_nx, quo_nx};
  assign busy   = state_q == CALC;
  assign done   = state_q == FIN;
  assign err    = err_q;
  assign result = res_q;
  seq_alu_divider #(.WIDTH(WIDTH)) u_div (
    .clk       (hz100),
    .load_i    (accept),
    .step_i    (state_q == CALC && op_q == OP_DIV),
    .dividend_i(val_a),
    .divisor_i (b_q),
    .rem_o     (rem_nx),
    .quo_o     (quo_nx)
  );
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (accept) begin
      state_d = CALC;
      cnt_d   = (opcode == OP_MUL || (opcode == OP_DIV && val_b != '0)) ? CW'(WIDTH - 1) : '0;
    end else if (state_q == CALC) begin
      state_d = last ? FIN : CALC;
      cnt_d   = cnt_q - 1'b1;
    end else if (state_q == FIN) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge hz100) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        op_q     <= opcode;
        a_q      <= val_a;
        b_q      <= val_b;
        mplier_q <= val_a;
        mcand_q  <= {{WIDTH{1'b0}}, val_b};
        acc_q    <= '0;
        err_q    <= 1'b0;
      end else if (state_q == CALC) begin
        mplier_q <= mplier_q >> 1;
        mcand_q  <= mcand_q << 1;
        acc_q    <= acc_nx;
        if (last) begin
          res_q <= res_nx;
          err_q <= err_nx;
        end
      end
    end
  end
endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed-vector self-checking bench for seq_alu at WIDTH=16.
module tb_seq_alu;
  import seq_alu_pkg::*;
  logic        hz100 = 1'b0, reset = 1'b1, start = 1'b0;
  logic [3:0]  opcode = '0;
  logic [15:0] val_a = '0, val_b = '0;
  logic        busy, done, err;
  logic [31:0] result;
  int          n_checks = 0, n_errors = 0;
  int          lat, bc, dc;
`ifdef SEQ_ALU_EARLY_EXIT_EN
  localparam int LAT_M3 = 3, LAT_M0 = 2;
`else
  localparam int LAT_M3 = 17, LAT_M0 = 17;
`endif
  seq_alu #(.WIDTH(16)) dut (
    .hz100 (hz100),
    .reset (reset),
    .start (start),
    .opcode(opcode),
    .val_a (val_a),
    .val_b (val_b),
    .busy  (busy),
    .done  (done),
    .err   (err),
    .result(result)
  );
  always #5 hz100 = ~hz100;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic launch(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    start  = 1'b1;
    opcode = op;
    val_a  = a;
    val_b  = b;
  endtask
  // lat counts edges from the edge just before start was raised until done is seen
  task automatic wait_done(output int l, output int busy_cnt);
    l = 0;
    busy_cnt = 0;
    do begin
      @(posedge hz100); #1;
      if (l == 0) start = 1'b0;
      l++;
      busy_cnt += int'(busy);
    end while (!done && l < 100);
  endtask
  task automatic do_op(input string tag, input logic [3:0] op, input logic [15:0] a,
                       input logic [15:0] b, input logic [31:0] er, input logic ee, input int el);
    @(posedge hz100); #1;
    launch(op, a, b);
    wait_done(lat, bc);
    check({tag, "_lat"}, lat, el);
    check({tag, "_res"}, result, er);
    check({tag, "_err"}, err, ee);
    check({tag, "_busy"}, bc, el - 1);
  endtask
  initial begin
    repeat (2) @(posedge hz100);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_res", result, 0);
    reset = 1'b0;
    do_op("add", OP_ADD, 16'h1234, 16'h0FFF, 32'h0000_2233, 0, 2);
    @(posedge hz100); #1;
    check("done_pulse", done, 0);
    do_op("sub", OP_SUB, 16'h0003, 16'h0005, 32'hFFFF_FFFE, 0, 2);
    do_op("mul_max", OP_MUL, 16'hFFFF, 16'hFFFF, 32'hFFFE_0001, 0, 17);
    do_op("mul_3x7", OP_MUL, 16'h0003, 16'h0007, 32'h0000_0015, 0, LAT_M3);
    do_op("mul_zero", OP_MUL, 16'h0000, 16'h1234, 32'h0000_0000, 0, LAT_M0);
    do_op("div", OP_DIV, 16'h0064, 16'h0007, 32'h0002_000E, 0, 17);
    do_op("div_one", OP_DIV, 16'hFFFF, 16'h0001, 32'h0000_FFFF, 0, 17);
    do_op("div_zero", OP_DIV, 16'h1234, 16'h0000, 32'h0000_0000, 1, 2);
    do_op("add_clr0", OP_ADD, 16'h0001, 16'h0001, 32'h0000_0002, 0, 2);
    do_op("illegal", 4'hF, 16'h1111, 16'h2222, 32'h0000_0000, 1, 2);
    do_op("add_clr", OP_ADD, 16'h0001, 16'h0001, 32'h0000_0002, 0, 2);
    // back-to-back: second MUL launched during FIN of the first
    do_op("b2b_1", OP_MUL, 16'h8001, 16'h0002, 32'h0001_0002, 0, 17);
    launch(OP_MUL, 16'hFFFF, 16'h0002);
    @(posedge hz100); #1;
    start = 1'b0;
    check("b2b_busy", busy, 1);
    lat = 1;
    while (!done && lat < 100) begin
      @(posedge hz100); #1;
      lat++;
    end
    check("b2b_lat", lat, 17);
    check("b2b_res", result, 32'h0001_FFFE);
    // start pulsed mid-MUL must be ignored
    @(posedge hz100); #1;
    launch(OP_MUL, 16'h8000, 16'h0003);
    @(posedge hz100); #1;
    start = 1'b0;
    lat = 1;
    repeat (3) begin
      @(posedge hz100); #1;
      lat++;
    end
    launch(OP_ADD, 16'h0005, 16'h0005);
    @(posedge hz100); #1;
    start = 1'b0;
    lat++;
    while (!done && lat < 100) begin
      @(posedge hz100); #1;
      lat++;
    end
    check("ign_lat", lat, 17);
    check("ign_res", result, 32'h0001_8000);
    // reset during the 8th CALC cycle aborts the MUL
    @(posedge hz100); #1;
    launch(OP_MUL, 16'hFFFF, 16'hFFFF);
    @(posedge hz100); #1;
    start = 1'b0;
    repeat (7) @(posedge hz100);
    #1;
    check("abort_busy_pre", busy, 1);
    reset = 1'b1;
    @(posedge hz100); #1;
    reset = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_err", err, 0);
    check("abort_res", result, 0);
    dc = 0;
    repeat (20) begin
      @(posedge hz100); #1;
      dc += int'(done);
    end
    check("abort_no_done", dc, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
